axi4_arch_sender: RTL and testbench
===================================

// Module: axi4_arch_sender
// PURPOSE
//  AR-channel stage of the RAB read path, directly upstream of the R-channel responder.
//  - Accepts one slave-side AR beat and requests a RAB lookup for its address.
//  - Translation hit: forwards the AR with the physical address to the master side.
//  - Miss or protection fault: drops the AR and hands its ID to the R-channel responder,
//    which returns a single SLVERR beat. Also latches miss info for the host.
// PARAMETERS
//  C_AXI_ADDR_WIDTH  32  AR address width, virtual and physical
//  C_AXI_ID_WIDTH    4   AR ID width; must equal the R-channel responder's ID width
//  C_AXI_USER_WIDTH  4   AR user width
// PORTS
//  axi4_aclk          in   1   clock
//  axi4_arstn         in   1   asynchronous, active-low reset
//  s_axi4_araddr      in   AW  virtual address
//  s_axi4_arid        in   IW  transaction ID
//  s_axi4_arlen       in   8   burst length
//  s_axi4_arsize      in   3   beat size
//  s_axi4_arburst     in   2   burst type
//  s_axi4_arprot      in   3   protection
//  s_axi4_aruser      in   UW  user sideband
//  s_axi4_arvalid     in   1   slave AR valid
//  s_axi4_arready     out  1   slave AR ready
//  lookup_req         out  1   lookup request; held until lookup_done
//  lookup_addr        out  AW  registered virtual address under lookup
//  lookup_done        in   1   lookup result valid, single-cycle
//  lookup_drop        in   1   1 = miss or fault; qualified by lookup_done
//  lookup_paddr       in   AW  physical address; qualified by lookup_done
//  m_axi4_araddr/id/len/size/burst/prot/user  out  as s_  translated AR fields
//  m_axi4_arvalid     out  1   master AR valid
//  m_axi4_arready     in   1   master AR ready
//  trans_id           out  IW  ID of the dropped transaction, to the R-channel responder
//  trans_drop         out  1   one-cycle drop push, to the R-channel responder
//  trans_ready        in   1   R-channel responder FIFO not full
//  miss_valid         out  1   sticky: miss info valid
//  miss_addr          out  AW  captured virtual address of the first miss
//  miss_id            out  IW  captured ID of the first miss
//  miss_overflow      out  1   sticky: a further miss occurred while miss_valid was set
//  miss_clr           in   1   one-cycle clear of miss_valid and miss_overflow
// BEHAVIOUR
//  - FSM states: IDLE, LOOKUP, FWD, DROP. Reset: IDLE.
//  - Reset values: every output 0 except m_ data fields, which are don't-care (0 in RTL).
//  - IDLE:
//    - s_axi4_arready=1 and no other state asserts it, so only one AR is in flight.
//    - On arvalid&arready, register all AR fields, go to LOOKUP.
//  - LOOKUP:
//    - lookup_req=1 from the first cycle after acceptance. lookup_done may arrive that same cycle.
//    - On lookup_done: drop=0 -> FWD with araddr:=lookup_paddr; drop=1 -> DROP.
//  - FWD:
//    - m_axi4_arvalid=1 with stable fields until m_axi4_arready.
//    - After the handshake go to IDLE; next s_arready is the following cycle.
//    - Minimum latency from s handshake to m_arvalid: 2 cycles (done in the first LOOKUP cycle).
//  - DROP:
//    - trans_drop=trans_ready, trans_id=registered ID.
//    - Leave to IDLE on the cycle trans_drop=1, giving exactly one pulse per dropped AR.
//    - While trans_ready=0, stall in DROP with trans_drop=0.
//    - m_axi4_arvalid is never asserted for a dropped AR.
//  - Miss capture, on the LOOKUP->DROP transition:
//    - miss_valid=0: load miss_addr/miss_id, set miss_valid.
//    - miss_valid=1: set miss_overflow, leave addr/id unchanged.
//    - miss_clr in the same cycle as a capture: clear is applied first, so the new miss is
//      captured and miss_overflow ends at 0.
//    - miss_clr with no capture: both flags go to 0; addr/id are held.
//  - Protocol: m_arvalid is never deasserted before arready. lookup_done outside LOOKUP is ignored.
//  - Reset mid-operation: async return to IDLE; the in-flight AR is discarded and not dropped.
//  - Dropped bursts of any arlen get one SLVERR beat, by the R-channel responder's contract.
// TESTING
//  - Hit: AR addr=0x1000 id=3; done 1 cycle later, paddr=0x8000_1000 -> m_arvalid 2 cycles
//    after the s handshake, addr=0x8000_1000 id=3 len unchanged.
//  - Backpressure: m_arready held 0 for 5 cycles -> m_ fields stable and s_arready=0 throughout.
//  - Drop: lookup_drop=1, id=5, trans_ready=1 -> a single trans_drop pulse with trans_id=5,
//    miss_valid=1, miss_addr=AR addr.
//  - Full FIFO: drop with trans_ready=0 for 4 cycles -> no pulse; exactly one pulse in the
//    cycle trans_ready rises.
//  - Second miss without clear -> miss_overflow=1, miss_addr still first. miss_clr coinciding
//    with a third miss -> miss_valid=1, new addr, overflow=0.
//  - Reset asserted in FWD -> m_arvalid=0 asynchronously; after release s_arready=1 and no trans_drop.

Source files
------------

// File: rtl/axi4_arch_sender_if.sv
// AXI4 read-address channel bundle.
// One instance per side of the AR stage.
interface axi4_arch_sender_if #(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_USER_WIDTH = 4
);
  logic [C_AXI_ADDR_WIDTH-1:0] addr;
  logic [C_AXI_ID_WIDTH-1:0]   id;
  logic [7:0]                  len;
  logic [2:0]                  size;
  logic [1:0]                  burst;
  logic [2:0]                  prot;
  logic [C_AXI_USER_WIDTH-1:0] user;
  logic                        valid;
  logic                        ready;

  modport master (
    output addr, id, len, size, burst,
    output prot, user, valid,
    input  ready
  );

  modport slave (
    input  addr, id, len, size, burst,
    input  prot, user, valid,
    output ready
  );
endinterface

// File: rtl/axi4_arch_sender.sv
// AR-channel stage of the RAB read path: lookup,
// forward on hit, drop to the R responder on miss.
module axi4_arch_sender #(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_USER_WIDTH = 4
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_arstn,
  axi4_arch_sender_if.slave           s_ar,
  axi4_arch_sender_if.master          m_ar,
  output logic                        lookup_req,
  output logic [C_AXI_ADDR_WIDTH-1:0] lookup_addr,
  input  logic                        lookup_done,
  input  logic                        lookup_drop,
  input  logic [C_AXI_ADDR_WIDTH-1:0] lookup_paddr,
  output logic [C_AXI_ID_WIDTH-1:0]   trans_id,
  output logic                        trans_drop,
  input  logic                        trans_ready,
  output logic                        miss_valid,
  output logic [C_AXI_ADDR_WIDTH-1:0] miss_addr,
  output logic [C_AXI_ID_WIDTH-1:0]   miss_id,
  output logic                        miss_overflow,
  input  logic                        miss_clr
);

  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int IW = C_AXI_ID_WIDTH;
  localparam int UW = C_AXI_USER_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FWD    = 2'd2,
    DROP   = 2'd3
  } state_t;

  state_t        state;
  logic          arready_q;
  logic          req_q;
  logic          mvalid_q;
  logic [AW-1:0] vaddr_q;
  logic [AW-1:0] addr_q;
  logic [IW-1:0] id_q;
  logic [7:0]    len_q;
  logic [2:0]    size_q;
  logic [1:0]    burst_q;
  logic [2:0]    prot_q;
  logic [UW-1:0] user_q;
  logic          capture;

  assign s_ar.ready  = arready_q;
  assign m_ar.valid  = mvalid_q;
  assign m_ar.addr   = addr_q;
  assign m_ar.id     = id_q;
  assign m_ar.len    = len_q;
  assign m_ar.size   = size_q;
  assign m_ar.burst  = burst_q;
  assign m_ar.prot   = prot_q;
  assign m_ar.user   = user_q;
  assign lookup_req  = req_q;
  assign lookup_addr = vaddr_q;
  assign trans_id    = id_q;

  // The push follows FIFO space so each drop is
  // pushed in exactly one cycle.
  assign trans_drop = (state == DROP) && trans_ready;

  assign capture = (state == LOOKUP)
                && lookup_done
                && lookup_drop;

  // Main FSM: one AR in flight, registered outputs.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      state     <= IDLE;
      arready_q <= 1'b0;
      req_q     <= 1'b0;
      mvalid_q  <= 1'b0;
      vaddr_q   <= '0;
      addr_q    <= '0;
      id_q      <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      prot_q    <= '0;
      user_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          arready_q <= 1'b1;
          if (s_ar.valid && arready_q) begin
            vaddr_q   <= s_ar.addr;
            addr_q    <= s_ar.addr;
            id_q      <= s_ar.id;
            len_q     <= s_ar.len;
            size_q    <= s_ar.size;
            burst_q   <= s_ar.burst;
            prot_q    <= s_ar.prot;
            user_q    <= s_ar.user;
            arready_q <= 1'b0;
            req_q     <= 1'b1;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lookup_done) begin
            req_q <= 1'b0;
            if (lookup_drop) begin
              state <= DROP;
            end else begin
              addr_q   <= lookup_paddr;
              mvalid_q <= 1'b1;
              state    <= FWD;
            end
          end
        end
        FWD: begin
          if (m_ar.ready) begin
            mvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            state     <= IDLE;
          end
        end
        DROP: begin
          if (trans_ready) begin
            arready_q <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

  // Miss capture; a coincident clear lets the new
  // miss load as if the register were empty.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      miss_valid    <= 1'b0;
      miss_addr     <= '0;
      miss_id       <= '0;
      miss_overflow <= 1'b0;
    end else if (capture) begin
      if (miss_clr || !miss_valid) begin
        miss_valid    <= 1'b1;
        miss_addr     <= vaddr_q;
        miss_id       <= id_q;
        miss_overflow <= 1'b0;
      end else begin
        miss_overflow <= 1'b1;
      end
    end else if (miss_clr) begin
      miss_valid    <= 1'b0;
      miss_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_arch_sender.sv
// Directed and random bench for axi4_arch_sender.
// Expected values come from a transaction-level model.
module tb_axi4_arch_sender;

  localparam int AW = 32;
  localparam int IW = 4;
  localparam int UW = 4;

  logic          clk;
  logic          arstn;
  logic          lookup_req;
  logic [AW-1:0] lookup_addr;
  logic          lookup_done;
  logic          lookup_drop;
  logic [AW-1:0] lookup_paddr;
  logic [IW-1:0] trans_id;
  logic          trans_drop;
  logic          trans_ready;
  logic          miss_valid;
  logic [AW-1:0] miss_addr;
  logic [IW-1:0] miss_id;
  logic          miss_overflow;
  logic          miss_clr;

  int checks = 0;
  int errors = 0;

  // Miss register model
  logic          mv;
  logic [AW-1:0] ma;
  logic [IW-1:0] mi;
  logic          mo;

  axi4_arch_sender_if #(
    .C_AXI_ADDR_WIDTH(AW),
    .C_AXI_ID_WIDTH(IW),
    .C_AXI_USER_WIDTH(UW)
  ) s_ar ();

  axi4_arch_sender_if #(
    .C_AXI_ADDR_WIDTH(AW),
    .C_AXI_ID_WIDTH(IW),
    .C_AXI_USER_WIDTH(UW)
  ) m_ar ();

  axi4_arch_sender #(
    .C_AXI_ADDR_WIDTH(AW),
    .C_AXI_ID_WIDTH(IW),
    .C_AXI_USER_WIDTH(UW)
  ) dut (
    .axi4_aclk    (clk),
    .axi4_arstn   (arstn),
    .s_ar         (s_ar),
    .m_ar         (m_ar),
    .lookup_req   (lookup_req),
    .lookup_addr  (lookup_addr),
    .lookup_done  (lookup_done),
    .lookup_drop  (lookup_drop),
    .lookup_paddr (lookup_paddr),
    .trans_id     (trans_id),
    .trans_drop   (trans_drop),
    .trans_ready  (trans_ready),
    .miss_valid   (miss_valid),
    .miss_addr    (miss_addr),
    .miss_id      (miss_id),
    .miss_overflow(miss_overflow),
    .miss_clr     (miss_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_miss(input string tag);
    chk({tag, "_mv"}, 64'(miss_valid), 64'(mv));
    chk({tag, "_ma"}, 64'(miss_addr), 64'(ma));
    chk({tag, "_mi"}, 64'(miss_id), 64'(mi));
    chk({tag, "_mo"}, 64'(miss_overflow), 64'(mo));
  endtask

  // One full AR transaction.
  // dw: extra LOOKUP cycles before done
  // rw: cycles of m_arready/trans_ready low
  task automatic txn(input logic [AW-1:0] a,
                     input logic [IW-1:0] i,
                     input logic [7:0] l,
                     input logic drop,
                     input logic [AW-1:0] pa,
                     input int dw,
                     input int rw,
                     input logic clr);
    logic [2:0]    sz;
    logic [1:0]    bu;
    logic [2:0]    pr;
    logic [UW-1:0] us;
    sz = 3'($urandom);
    bu = 2'($urandom);
    pr = 3'($urandom);
    us = UW'($urandom);
    for (int k = 0; k < 10 && s_ar.ready !== 1'b1; k++)
      step();
    chk("s_ready_idle", 64'(s_ar.ready), 64'd1);
    s_ar.addr  = a;
    s_ar.id    = i;
    s_ar.len   = l;
    s_ar.size  = sz;
    s_ar.burst = bu;
    s_ar.prot  = pr;
    s_ar.user  = us;
    s_ar.valid = 1'b1;
    step();
    s_ar.valid = 1'b0;
    s_ar.addr  = '0;
    chk("lookup_req", 64'(lookup_req), 64'd1);
    chk("lookup_addr", 64'(lookup_addr), 64'(a));
    chk("s_ready_busy", 64'(s_ar.ready), 64'd0);
    for (int k = 0; k < dw; k++) begin
      step();
      chk("req_hold", 64'(lookup_req), 64'd1);
      chk("no_mvalid", 64'(m_ar.valid), 64'd0);
    end
    lookup_done  = 1'b1;
    lookup_drop  = drop;
    lookup_paddr = pa;
    miss_clr     = clr;
    if (drop) begin
      if (clr || !mv) begin
        mv = 1'b1;
        ma = a;
        mi = i;
        mo = 1'b0;
      end else begin
        mo = 1'b1;
      end
    end else if (clr) begin
      mv = 1'b0;
      mo = 1'b0;
    end
    step();
    lookup_done  = 1'b0;
    lookup_drop  = 1'b0;
    miss_clr     = 1'b0;
    chk("req_done", 64'(lookup_req), 64'd0);
    chk_miss("miss");
    if (!drop) begin
      for (int k = 0; k <= rw; k++) begin
        chk("m_valid", 64'(m_ar.valid), 64'd1);
        chk("m_addr", 64'(m_ar.addr), 64'(pa));
        chk("m_id", 64'(m_ar.id), 64'(i));
        chk("m_len", 64'(m_ar.len), 64'(l));
        chk("m_misc",
            64'({m_ar.size, m_ar.burst,
                 m_ar.prot, m_ar.user}),
            64'({sz, bu, pr, us}));
        chk("s_ready_fwd", 64'(s_ar.ready), 64'd0);
        chk("no_drop_fwd", 64'(trans_drop), 64'd0);
        if (k == rw) m_ar.ready = 1'b1;
        step();
      end
      m_ar.ready = 1'b0;
      chk("m_valid_off", 64'(m_ar.valid), 64'd0);
      chk("s_ready_ret", 64'(s_ar.ready), 64'd1);
    end else begin
      for (int k = 0; k < rw; k++) begin
        chk("drop_stall", 64'(trans_drop), 64'd0);
        chk("no_mv_drop", 64'(m_ar.valid), 64'd0);
        step();
      end
      trans_ready = 1'b1;
      #1;
      chk("drop_pulse", 64'(trans_drop), 64'd1);
      chk("drop_id", 64'(trans_id), 64'(i));
      chk("no_mv_drop", 64'(m_ar.valid), 64'd0);
      step();
      chk("drop_once", 64'(trans_drop), 64'd0);
      trans_ready = 1'b0;
      chk("s_ready_ret", 64'(s_ar.ready), 64'd1);
    end
  endtask

  initial begin
    arstn        = 1'b0;
    s_ar.addr    = '0;
    s_ar.id      = '0;
    s_ar.len     = '0;
    s_ar.size    = '0;
    s_ar.burst   = '0;
    s_ar.prot    = '0;
    s_ar.user    = '0;
    s_ar.valid   = 1'b0;
    m_ar.ready   = 1'b0;
    lookup_done  = 1'b0;
    lookup_drop  = 1'b0;
    lookup_paddr = '0;
    trans_ready  = 1'b0;
    miss_clr     = 1'b0;
    mv = 1'b0;
    ma = '0;
    mi = '0;
    mo = 1'b0;

    repeat (3) step();
    chk("rst_s_ready", 64'(s_ar.ready), 64'd0);
    chk("rst_req", 64'(lookup_req), 64'd0);
    chk("rst_m_valid", 64'(m_ar.valid), 64'd0);
    chk("rst_drop", 64'(trans_drop), 64'd0);
    chk_miss("rst");

    arstn = 1'b1;
    step();

    // Hit, done in first LOOKUP cycle
    txn(32'h1000, 4'd3, 8'd7, 1'b0,
        32'h8000_1000, 0, 0, 1'b0);
    // Backpressure 5 cycles
    txn(32'h2040, 4'd9, 8'd15, 1'b0,
        32'h9000_0040, 1, 5, 1'b0);
    // Drop with space in FIFO
    txn(32'h3000, 4'd5, 8'd3, 1'b1,
        32'h0, 0, 0, 1'b0);
    // Drop against a full FIFO, second miss
    txn(32'h4000, 4'd6, 8'd0, 1'b1,
        32'h0, 2, 4, 1'b0);
    // Third miss with coincident clear
    txn(32'h5000, 4'd7, 8'd255, 1'b1,
        32'h0, 0, 1, 1'b1);

    // Clear with no capture
    miss_clr = 1'b1;
    mv = 1'b0;
    mo = 1'b0;
    step();
    miss_clr = 1'b0;
    chk_miss("clr_only");

    // Random mix
    for (int n = 0; n < 30; n++) begin
      txn($urandom, 4'($urandom), 8'($urandom),
          1'($urandom_range(0, 1)), $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3),
          ($urandom_range(0, 3) == 0));
    end

    // Reset while in FWD
    for (int k = 0; k < 10 && s_ar.ready !== 1'b1; k++)
      step();
    s_ar.addr  = 32'h6000;
    s_ar.id    = 4'd2;
    s_ar.valid = 1'b1;
    step();
    s_ar.valid   = 1'b0;
    lookup_done  = 1'b1;
    lookup_drop  = 1'b0;
    lookup_paddr = 32'hA000_6000;
    step();
    lookup_done = 1'b0;
    chk("rst_fwd_pre", 64'(m_ar.valid), 64'd1);
    #2;
    arstn = 1'b0;
    #1;
    chk("rst_async_mv", 64'(m_ar.valid), 64'd0);
    chk("rst_async_req", 64'(lookup_req), 64'd0);
    @(negedge clk);
    arstn = 1'b1;
    trans_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_no_drop", 64'(trans_drop), 64'd0);
      chk("rst_no_mv", 64'(m_ar.valid), 64'd0);
    end
    chk("rst_s_ready_up", 64'(s_ar.ready), 64'd1);
    trans_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
